// File: rtl/rrstream_pkg.sv
// Shared definitions for the rrstream family (demux and arbiter):
// destination-tag width helper and the payload typedefs for the default
// configuration.
package rrstream_pkg;

    localparam int DEF_QUEUE_COUNT = 3;
    localparam int DEF_DATA_WIDTH  = 8;

    // Width of the dst tag; never narrower than one bit.
    function automatic int dst_width(input int queue_count);
        return (queue_count > 1) ? $clog2(queue_count) : 1;
    endfunction

    localparam int DEF_DST_WIDTH = dst_width(DEF_QUEUE_COUNT);

    // Tagged input beat: destination index plus data.
    typedef struct packed {
        logic [DEF_DST_WIDTH-1:0]  dst;
        logic [DEF_DATA_WIDTH-1:0] p;
    } rr_in_payload_t;

    // Output beat: data only, tag stripped.
    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0] p;
    } rr_out_payload_t;

endpackage

// File: rtl/rrstream_demux_fifo.sv
// Two-entry FIFO used as the per-destination output buffer. Full means
// no push this cycle, even if a pop happens in the same cycle.
module rrstream_demux_fifo
    import rrstream_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_full,
    output logic                  o_empty
);

    logic [DATA_WIDTH-1:0] r_mem [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign o_full    = (r_count == 2'd2);
    assign o_empty   = (r_count == 2'd0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr];

    // Storage write; validity is tracked by r_count, so no reset needed here.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy update; reset empties the FIFO immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/rrstream_demux.sv
// Tagged-stream demultiplexer: routes each input beat to the output
// selected by its dst tag through a 2-entry FIFO per output. Beats with an
// out-of-range dst are accepted, discarded and counted (saturating).
module rrstream_demux
    import rrstream_pkg::*;
#(
    parameter  int QUEUE_COUNT = 3,
    parameter  int DATA_WIDTH  = 8,
    parameter  int DROP_WIDTH  = 16,
    localparam int DST_W       = dst_width(QUEUE_COUNT)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  i_in_valid,
    output logic                                  o_in_ready,
    input  logic [DST_W-1:0]                      i_in_dst,
    input  logic [DATA_WIDTH-1:0]                 i_in_p,
    output logic [QUEUE_COUNT-1:0]                o_out_valid,
    input  logic [QUEUE_COUNT-1:0]                i_out_ready,
    output logic [QUEUE_COUNT-1:0][DATA_WIDTH-1:0] o_out_p,
    output logic [DROP_WIDTH-1:0]                 o_drop_count
);

    logic [QUEUE_COUNT-1:0] w_full;
    logic [QUEUE_COUNT-1:0] w_empty;
    logic [QUEUE_COUNT-1:0] w_push;
    logic [QUEUE_COUNT-1:0] w_pop;
    logic                   w_dst_legal;
    logic                   w_sel_full;
    logic                   w_accept;
    logic [DROP_WIDTH-1:0]  r_drop_count;

    // One extra bit so QUEUE_COUNT itself is representable when it is a power of two.
    assign w_dst_legal = ({1'b0, i_in_dst} < (DST_W+1)'(QUEUE_COUNT));

    // Full flag of the addressed FIFO; illegal tags select nothing.
    always_comb begin
        w_sel_full = 1'b0;
        for (int i = 0; i < QUEUE_COUNT; i++) begin
            if (i_in_dst == DST_W'(i)) begin
                w_sel_full = w_full[i];
            end
        end
    end

    // Ready depends only on dst and occupancy; held low while in reset.
    assign o_in_ready = rst_n && (!w_dst_legal || !w_sel_full);
    assign w_accept   = i_in_valid && o_in_ready;

    generate
        for (genvar gi = 0; gi < QUEUE_COUNT; gi++) begin : g_out
            assign w_push[gi]      = w_accept && w_dst_legal && (i_in_dst == DST_W'(gi));
            assign w_pop[gi]       = i_out_ready[gi] && !w_empty[gi];
            assign o_out_valid[gi] = !w_empty[gi];

            rrstream_demux_fifo #(
                .DATA_WIDTH (DATA_WIDTH)
            ) u_fifo (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_push  (w_push[gi]),
                .i_data  (i_in_p),
                .i_pop   (w_pop[gi]),
                .o_data  (o_out_p[gi]),
                .o_full  (w_full[gi]),
                .o_empty (w_empty[gi])
            );
        end
    endgenerate

    // Saturating count of beats discarded for an out-of-range dst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_count <= '0;
        end else if (w_accept && !w_dst_legal && (r_drop_count != '1)) begin
            r_drop_count <= r_drop_count + 1'b1;
        end
    end

    assign o_drop_count = r_drop_count;

endmodule

// File: doc/rrstream_demux.md
RRSTREAM_DEMUX -- requirements
Module: rrstream_demux

Interface
REQ-001 Parameter QUEUE_COUNT, default 3: number of output streams; legal range 2..16.
REQ-002 Parameter DATA_WIDTH, default 8: width of payload data field p.
REQ-003 Parameter DROP_WIDTH, default 16: width of drop counter.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in  slave stream  valid/ready + payload {dst[$clog2(QUEUE_COUNT)], p[DATA_WIDTH]}  tagged input stream.
REQ-007 out[QUEUE_COUNT]  master stream array  valid/ready + payload p[DATA_WIDTH]  per-destination output streams.
REQ-008 drop_count  output  DROP_WIDTH  count of beats dropped for illegal dst.

Function
REQ-009 SHALL route each accepted beat to out[in.payload.dst] only, with dst stripped and p unchanged.
REQ-010 SHALL hold one 2-entry FIFO per output; a beat accepted at edge N is visible on out[dst].valid/payload after edge N (latency 1 cycle).
REQ-011 in.ready SHALL be a function of in.payload.dst and FIFO occupancy only, never of in.valid.
REQ-012 in.ready SHALL be 1 when dst < QUEUE_COUNT and FIFO[dst] holds fewer than 2 entries, else 0 for legal dst.
REQ-013 Full FIFO SHALL deassert in.ready even if out[dst].ready pops in the same cycle (no full-state passthrough).
REQ-014 Head-of-line blocking SHALL apply: a beat stalled on a full FIFO blocks all later beats regardless of their dst.
REQ-015 Beats with dst >= QUEUE_COUNT SHALL be accepted (in.ready=1), discarded, and increment drop_count by 1.
REQ-016 drop_count SHALL saturate at 2^DROP_WIDTH-1 and never wrap.
REQ-017 out[i].valid SHALL equal "FIFO[i] non-empty"; out[i].payload SHALL be FIFO[i] head.
REQ-018 Once out[i].valid is 1, valid and payload SHALL remain stable until out[i].ready is 1.
REQ-019 Simultaneous push and pop on a FIFO holding 1 entry SHALL leave occupancy 1 with correct ordering.
REQ-020 Per-destination order SHALL equal input acceptance order; no beat duplicated or lost for legal dst.
REQ-021 With all out[i].ready=1, sustained throughput SHALL be one beat per cycle for any dst sequence.

Reset
REQ-022 While rst_n=0: in.ready=0, every out[i].valid=0, drop_count=0, all FIFOs empty.
REQ-023 Reset assertion mid-transfer SHALL discard all buffered beats immediately (asynchronous).
REQ-024 First acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-025 Payload typedefs (tagged in-payload, data-only out-payload) and dst width function SHALL live in shared package rrstream_pkg, also used by rrstream_arbiter.
REQ-026 Per-output buffer SHALL be sub-module rrstream_demux_fifo (2 entries, push/pop/full/empty, async active-low reset), instantiated QUEUE_COUNT times via generate.
REQ-027 drop counter and input-ready mux SHALL live in the top level.

Verification
REQ-028 Reset, then in.valid=1 dst=1 p=0xA5, all ready=1 -> in.ready=1, out[1].valid=1 p=0xA5 next cycle, out[0]/out[2].valid=0.
REQ-029 out[0].ready=0, send p=0x01,0x02,0x03 to dst=0 -> first two accepted, third stalls with in.ready=0; raise out[0].ready -> emerges 0x01,0x02,0x03 in order.
REQ-030 QUEUE_COUNT=3, send dst=3 p=0x55 five times -> all accepted, no out valid, drop_count=5.
REQ-031 All ready=1, 100 back-to-back beats with dst cycling 0,1,2 -> in.ready=1 every cycle, each output receives its 33/34 beats in order.
REQ-032 rst_n pulsed low while FIFO[2] holds 2 beats -> out[2].valid=0 immediately, drop_count=0, no stale beat after release.
REQ-033 Formal: per-destination fifo_tracker plus stream assertions on every out[i] and assumptions on in prove REQ-018/020 for QUEUE_COUNT=2 and 3.
